// File: rtl/sy_pkg.sv
// Shared types and constants for the FP writeback slice.
package sy_pkg;

   localparam int unsigned DWTH    = 64;
   localparam int unsigned FP_NREG = 32;
   localparam int unsigned IDXW    = 5;

   // Hazard sources checked by decode: rs1, rs2, rs3, rd (rd is the last slot).
   localparam int unsigned NSRC    = 4;
   localparam int unsigned RD_SLOT = 3;

   typedef struct packed {
      logic [IDXW-1:0] idx;
      logic [DWTH-1:0] data;
   } fp_wb_req_t;

   typedef enum logic [1:0] {
      WB_SRC_NONE,
      WB_SRC_LSU,
      WB_SRC_SKID,
      WB_SRC_FPU
   } wb_src_e;

   // Fixed-priority pick for the single FP register file write port.
   function automatic wb_src_e wb_pick(input logic lsu_vld, input logic skid_vld,
                                       input logic fpu_vld);
      if (lsu_vld)       return WB_SRC_LSU;
      else if (skid_vld) return WB_SRC_SKID;
      else if (fpu_vld)  return WB_SRC_FPU;
      else               return WB_SRC_NONE;
   endfunction

endpackage

// File: rtl/sy_ppl_fp_wb_if.sv
// Decode / FPU / LSU / FP register file connections of the FP writeback block.
interface sy_ppl_fp_wb_if;
   import sy_pkg::*;

   logic            dec_fp_wb__alloc_en;
   logic [IDXW-1:0] dec_fp_wb__alloc_idx;
   logic            dec_fp_wb__rs1_vld;
   logic [IDXW-1:0] dec_fp_wb__rs1_idx;
   logic            dec_fp_wb__rs2_vld;
   logic [IDXW-1:0] dec_fp_wb__rs2_idx;
   logic            dec_fp_wb__rs3_vld;
   logic [IDXW-1:0] dec_fp_wb__rs3_idx;
   logic            dec_fp_wb__rd_vld;
   logic [IDXW-1:0] dec_fp_wb__rd_idx;
   logic            fp_wb_dec__stall;

   logic            fpu_fp_wb__vld;
   logic [IDXW-1:0] fpu_fp_wb__idx;
   logic [DWTH-1:0] fpu_fp_wb__data;
   logic            fp_wb_fpu__rdy;

   logic            lsu_fp_wb__vld;
   logic [IDXW-1:0] lsu_fp_wb__idx;
   logic [DWTH-1:0] lsu_fp_wb__data;

   logic            fp_wb_fp_reg__rdst_en;
   logic [IDXW-1:0] fp_wb_fp_reg__rdst_idx;
   logic [DWTH-1:0] fp_wb_fp_reg__rdst_data;

   // Surrounding pipeline side.
   modport master (
      output dec_fp_wb__alloc_en, dec_fp_wb__alloc_idx,
             dec_fp_wb__rs1_vld, dec_fp_wb__rs1_idx,
             dec_fp_wb__rs2_vld, dec_fp_wb__rs2_idx,
             dec_fp_wb__rs3_vld, dec_fp_wb__rs3_idx,
             dec_fp_wb__rd_vld,  dec_fp_wb__rd_idx,
             fpu_fp_wb__vld, fpu_fp_wb__idx, fpu_fp_wb__data,
             lsu_fp_wb__vld, lsu_fp_wb__idx, lsu_fp_wb__data,
      input  fp_wb_dec__stall, fp_wb_fpu__rdy,
             fp_wb_fp_reg__rdst_en, fp_wb_fp_reg__rdst_idx, fp_wb_fp_reg__rdst_data
   );

   // Writeback block side.
   modport slave (
      input  dec_fp_wb__alloc_en, dec_fp_wb__alloc_idx,
             dec_fp_wb__rs1_vld, dec_fp_wb__rs1_idx,
             dec_fp_wb__rs2_vld, dec_fp_wb__rs2_idx,
             dec_fp_wb__rs3_vld, dec_fp_wb__rs3_idx,
             dec_fp_wb__rd_vld,  dec_fp_wb__rd_idx,
             fpu_fp_wb__vld, fpu_fp_wb__idx, fpu_fp_wb__data,
             lsu_fp_wb__vld, lsu_fp_wb__idx, lsu_fp_wb__data,
      output fp_wb_dec__stall, fp_wb_fpu__rdy,
             fp_wb_fp_reg__rdst_en, fp_wb_fp_reg__rdst_idx, fp_wb_fp_reg__rdst_data
   );

endinterface

// File: rtl/sy_ppl_fp_scoreboard.sv
// Pending-destination scoreboard for FP registers and the decode hazard stall.
// Optional macro SY_FP_WB_BYPASS_EN: sources matching the register being
// written this cycle are forwarded by the register file, and rd never stalls.
module sy_ppl_fp_scoreboard
   import sy_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      set_en,
   input  logic [IDXW-1:0]           set_idx,
   input  logic                      clr_en,
   input  logic [IDXW-1:0]           clr_idx,
   input  logic [NSRC-1:0]           src_vld,
   input  logic [NSRC-1:0][IDXW-1:0] src_idx,
   output logic                      stall
);

   logic [FP_NREG-1:0] busy_q;
   logic [FP_NREG-1:0] busy_d;

   // Next busy vector: clear on writeback, set on alloc (set wins), flush wins over all.
   always_comb begin
      busy_d = busy_q;
      if (clr_en) busy_d[clr_idx] = 1'b0;
      if (set_en) busy_d[set_idx] = 1'b1;
      if (flush)  busy_d = '0;
   end

   // Busy register, discarded immediately on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   // Stall when any used operand names a register still pending writeback.
   always_comb begin
      logic hit;
      stall = 1'b0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         hit = src_vld[i] && busy_q[src_idx[i]];
`ifdef SY_FP_WB_BYPASS_EN
         if ((i == RD_SLOT) || (clr_en && (clr_idx == src_idx[i]))) hit = 1'b0;
`endif
         stall = stall | hit;
      end
   end

endmodule

// File: rtl/sy_ppl_fp_wb.sv
// FP writeback arbiter: merges LSU FP loads (no back-pressure) and FPU results
// (valid/ready with a one-entry skid) onto the FP register file write port,
// and tracks pending destinations for decode hazard stalls.
// Optional macro SY_FP_WB_BYPASS_EN (see sy_ppl_fp_scoreboard).
module sy_ppl_fp_wb
   import sy_pkg::*;
(
   input logic           clk_i,
   input logic           rst_i,
   input logic           flush_i,
   sy_ppl_fp_wb_if.slave bus
);

   fp_wb_req_t fpu_req;
   fp_wb_req_t lsu_req;
   fp_wb_req_t skid_q;
   fp_wb_req_t skid_d;
   fp_wb_req_t wr_req;
   logic       skid_vld_q;
   logic       skid_vld_d;
   logic       fpu_xfer;
   logic       wr_en;
   wb_src_e    wr_src;

   assign fpu_req = '{idx: bus.fpu_fp_wb__idx, data: bus.fpu_fp_wb__data};
   assign lsu_req = '{idx: bus.lsu_fp_wb__idx, data: bus.lsu_fp_wb__data};

   // Ready depends only on the skid flop, so the FPU sees no combinational path.
   assign bus.fp_wb_fpu__rdy = ~skid_vld_q;
   assign fpu_xfer           = bus.fpu_fp_wb__vld & ~skid_vld_q;

   // Write port mux: LSU first, then the skid entry, then the FPU directly.
   always_comb begin
      wr_src = wb_pick(bus.lsu_fp_wb__vld, skid_vld_q, bus.fpu_fp_wb__vld);
      wr_en  = 1'b0;
      wr_req = '0;
      unique case (wr_src)
         WB_SRC_LSU:  begin wr_en = 1'b1; wr_req = lsu_req; end
         WB_SRC_SKID: begin wr_en = 1'b1; wr_req = skid_q;  end
         WB_SRC_FPU:  begin wr_en = 1'b1; wr_req = fpu_req; end
         WB_SRC_NONE: begin wr_en = 1'b0; wr_req = '0;      end
      endcase
   end

   assign bus.fp_wb_fp_reg__rdst_en   = wr_en;
   assign bus.fp_wb_fp_reg__rdst_idx  = wr_req.idx;
   assign bus.fp_wb_fp_reg__rdst_data = wr_req.data;

   // Skid next state: drains when it owns the port, captures an accepted FPU
   // result that lost the port to the LSU; flush drops the entry.
   always_comb begin
      skid_vld_d = skid_vld_q;
      skid_d     = skid_q;
      if (skid_vld_q) begin
         if (!bus.lsu_fp_wb__vld) skid_vld_d = 1'b0;
      end else if (fpu_xfer && bus.lsu_fp_wb__vld) begin
         skid_vld_d = 1'b1;
         skid_d     = fpu_req;
      end
      if (flush_i) skid_vld_d = 1'b0;
   end

   // Skid buffer registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         skid_vld_q <= 1'b0;
         skid_q     <= '0;
      end else begin
         skid_vld_q <= skid_vld_d;
         skid_q     <= skid_d;
      end
   end

   sy_ppl_fp_scoreboard u_scoreboard (
      .clk     (clk_i),
      .rst     (rst_i),
      .flush   (flush_i),
      .set_en  (bus.dec_fp_wb__alloc_en),
      .set_idx (bus.dec_fp_wb__alloc_idx),
      .clr_en  (wr_en),
      .clr_idx (wr_req.idx),
      .src_vld ({bus.dec_fp_wb__rd_vld, bus.dec_fp_wb__rs3_vld,
                 bus.dec_fp_wb__rs2_vld, bus.dec_fp_wb__rs1_vld}),
      .src_idx ({bus.dec_fp_wb__rd_idx, bus.dec_fp_wb__rs3_idx,
                 bus.dec_fp_wb__rs2_idx, bus.dec_fp_wb__rs1_idx}),
      .stall   (bus.fp_wb_dec__stall)
   );

endmodule

// File: tb/tb_sy_ppl_fp_wb.sv
// Self-checking bench for sy_ppl_fp_wb: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_sy_ppl_fp_wb;
   import sy_pkg::*;

`ifdef SY_FP_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic flush;
   int   total = 0;
   int   bad   = 0;

   sy_ppl_fp_wb_if bus ();

   sy_ppl_fp_wb dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (flush),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Reference model: set of pending registers and the list of accepted,
   // not-yet-written FPU results.
   bit [31:0]  m_busy;
   fp_wb_req_t m_skid[$];

   function automatic void model_write(output logic en, output logic [IDXW-1:0] idx,
                                       output logic [DWTH-1:0] data);
      en = 1'b1; idx = '0; data = '0;
      if (bus.lsu_fp_wb__vld) begin
         idx = bus.lsu_fp_wb__idx; data = bus.lsu_fp_wb__data;
      end else if (m_skid.size() != 0) begin
         idx = m_skid[0].idx; data = m_skid[0].data;
      end else if (bus.fpu_fp_wb__vld) begin
         idx = bus.fpu_fp_wb__idx; data = bus.fpu_fp_wb__data;
      end else begin
         en = 1'b0;
      end
   endfunction

   function automatic logic src_hazard(logic vld, logic [IDXW-1:0] idx, bit is_rd);
      logic en; logic [IDXW-1:0] widx; logic [DWTH-1:0] wdata;
      model_write(en, widx, wdata);
      if (!vld || !m_busy[idx]) return 1'b0;
      if (BYP && (is_rd || (en && widx == idx))) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic exp_stall();
      return src_hazard(bus.dec_fp_wb__rs1_vld, bus.dec_fp_wb__rs1_idx, 1'b0) |
             src_hazard(bus.dec_fp_wb__rs2_vld, bus.dec_fp_wb__rs2_idx, 1'b0) |
             src_hazard(bus.dec_fp_wb__rs3_vld, bus.dec_fp_wb__rs3_idx, 1'b0) |
             src_hazard(bus.dec_fp_wb__rd_vld,  bus.dec_fp_wb__rd_idx,  1'b1);
   endfunction

   task automatic drive_idle();
      flush = 1'b0;
      bus.dec_fp_wb__alloc_en = 1'b0; bus.dec_fp_wb__alloc_idx = '0;
      bus.dec_fp_wb__rs1_vld = 1'b0;  bus.dec_fp_wb__rs1_idx = '0;
      bus.dec_fp_wb__rs2_vld = 1'b0;  bus.dec_fp_wb__rs2_idx = '0;
      bus.dec_fp_wb__rs3_vld = 1'b0;  bus.dec_fp_wb__rs3_idx = '0;
      bus.dec_fp_wb__rd_vld = 1'b0;   bus.dec_fp_wb__rd_idx = '0;
      bus.fpu_fp_wb__vld = 1'b0; bus.fpu_fp_wb__idx = '0; bus.fpu_fp_wb__data = '0;
      bus.lsu_fp_wb__vld = 1'b0; bus.lsu_fp_wb__idx = '0; bus.lsu_fp_wb__data = '0;
   endtask

   // Advance the model by one clock edge using the current inputs, then the DUT.
   task automatic tick();
      logic en; logic [IDXW-1:0] widx; logic [DWTH-1:0] wdata;
      model_write(en, widx, wdata);
      if (rst) begin
         m_busy = '0; m_skid.delete();
      end else if (flush) begin
         m_busy = '0; m_skid.delete();
      end else begin
         if (en) m_busy[widx] = 1'b0;
         if (bus.dec_fp_wb__alloc_en) m_busy[bus.dec_fp_wb__alloc_idx] = 1'b1;
         if (bus.lsu_fp_wb__vld) begin
            if (bus.fpu_fp_wb__vld && m_skid.size() == 0)
               m_skid.push_back('{idx: bus.fpu_fp_wb__idx, data: bus.fpu_fp_wb__data});
         end else if (m_skid.size() != 0) begin
            void'(m_skid.pop_front());
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      bus.dec_fp_wb__rs1_vld = 1'b1; bus.dec_fp_wb__rs1_idx = 5'd0;
      #3;
      total++; if (bus.fp_wb_fpu__rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b exp=1", bus.fp_wb_fpu__rdy); end
      total++; if (bus.fp_wb_dec__stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", bus.fp_wb_dec__stall); end
      total++; if (bus.fp_wb_fp_reg__rdst_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%b exp=0", bus.fp_wb_fp_reg__rdst_en); end
      total++; if (bus.fp_wb_fp_reg__rdst_idx !== 5'd0 || bus.fp_wb_fp_reg__rdst_data !== '0) begin
         bad++; $display("FAIL reset_port got idx=%0d data=%h exp 0/0", bus.fp_wb_fp_reg__rdst_idx, bus.fp_wb_fp_reg__rdst_data); end
      rst = 1'b0;
      tick();
      drive_idle();
      #3;
      total++; if (bus.fp_wb_fpu__rdy !== 1'b1) begin bad++; $display("FAIL post_reset_rdy got=%b exp=1", bus.fp_wb_fpu__rdy); end
      tick();
   endtask

   task automatic test_raw_stall();
      bus.dec_fp_wb__alloc_en = 1'b1; bus.dec_fp_wb__alloc_idx = 5'd3;
      tick();
      bus.dec_fp_wb__alloc_en = 1'b0;
      bus.dec_fp_wb__rs1_vld = 1'b1; bus.dec_fp_wb__rs1_idx = 5'd3;
      #3;
      total++; if (bus.fp_wb_dec__stall !== 1'b1) begin bad++; $display("FAIL raw_stall got=%b exp=1", bus.fp_wb_dec__stall); end
      tick();
      bus.fpu_fp_wb__vld = 1'b1; bus.fpu_fp_wb__idx = 5'd3; bus.fpu_fp_wb__data = 64'h3FF0000000000000;
      #3;
      total++; if (bus.fp_wb_fp_reg__rdst_en !== 1'b1 || bus.fp_wb_fp_reg__rdst_idx !== 5'd3 ||
                   bus.fp_wb_fp_reg__rdst_data !== 64'h3FF0000000000000) begin
         bad++; $display("FAIL raw_fpu_write got en=%b idx=%0d data=%h exp 1/3/3ff0000000000000",
                         bus.fp_wb_fp_reg__rdst_en, bus.fp_wb_fp_reg__rdst_idx, bus.fp_wb_fp_reg__rdst_data); end
      total++; if (bus.fp_wb_dec__stall !== !BYP) begin bad++; $display("FAIL raw_stall_on_write got=%b exp=%b", bus.fp_wb_dec__stall, !BYP); end
      tick();
      bus.fpu_fp_wb__vld = 1'b0;
      #3;
      total++; if (bus.fp_wb_dec__stall !== 1'b0) begin bad++; $display("FAIL raw_stall_cleared got=%b exp=0", bus.fp_wb_dec__stall); end
      drive_idle();
      tick();
   endtask

   task automatic test_collision();
      bus.lsu_fp_wb__vld = 1'b1; bus.lsu_fp_wb__idx = 5'd5; bus.lsu_fp_wb__data = 64'hAA;
      bus.fpu_fp_wb__vld = 1'b1; bus.fpu_fp_wb__idx = 5'd6; bus.fpu_fp_wb__data = 64'hBB;
      #3;
      total++; if (bus.fp_wb_fp_reg__rdst_idx !== 5'd5 || bus.fp_wb_fp_reg__rdst_data !== 64'hAA) begin
         bad++; $display("FAIL coll_c0_write got idx=%0d data=%h exp 5/aa", bus.fp_wb_fp_reg__rdst_idx, bus.fp_wb_fp_reg__rdst_data); end
      total++; if (bus.fp_wb_fpu__rdy !== 1'b1) begin bad++; $display("FAIL coll_c0_rdy got=%b exp=1", bus.fp_wb_fpu__rdy); end
      tick();
      drive_idle();
      #3;
      total++; if (bus.fp_wb_fp_reg__rdst_en !== 1'b1 || bus.fp_wb_fp_reg__rdst_idx !== 5'd6 ||
                   bus.fp_wb_fp_reg__rdst_data !== 64'hBB) begin
         bad++; $display("FAIL coll_c1_skid got en=%b idx=%0d data=%h exp 1/6/bb",
                         bus.fp_wb_fp_reg__rdst_en, bus.fp_wb_fp_reg__rdst_idx, bus.fp_wb_fp_reg__rdst_data); end
      total++; if (bus.fp_wb_fpu__rdy !== 1'b0) begin bad++; $display("FAIL coll_c1_rdy got=%b exp=0", bus.fp_wb_fpu__rdy); end
      tick();
      #3;
      total++; if (bus.fp_wb_fpu__rdy !== 1'b1 || bus.fp_wb_fp_reg__rdst_en !== 1'b0) begin
         bad++; $display("FAIL coll_c2 got rdy=%b en=%b exp 1/0", bus.fp_wb_fpu__rdy, bus.fp_wb_fp_reg__rdst_en); end
      tick();
   endtask

   task automatic test_lsu_starve();
      bus.lsu_fp_wb__vld = 1'b1; bus.lsu_fp_wb__idx = 5'd10; bus.lsu_fp_wb__data = 64'h100;
      bus.fpu_fp_wb__vld = 1'b1; bus.fpu_fp_wb__idx = 5'd11; bus.fpu_fp_wb__data = 64'hA0A0;
      tick();
      bus.fpu_fp_wb__idx = 5'd12; bus.fpu_fp_wb__data = 64'hB0B0;
      for (int k = 1; k <= 3; k++) begin
         bus.lsu_fp_wb__idx = 5'(10 + 4 * k); bus.lsu_fp_wb__data = 64'(256 + k);
         #3;
         total++; if (bus.fp_wb_fpu__rdy !== 1'b0 || bus.fp_wb_fp_reg__rdst_idx !== 5'(10 + 4 * k)) begin
            bad++; $display("FAIL starve_c%0d got rdy=%b idx=%0d exp 0/%0d", k, bus.fp_wb_fpu__rdy,
                            bus.fp_wb_fp_reg__rdst_idx, 10 + 4 * k); end
         tick();
      end
      bus.lsu_fp_wb__vld = 1'b0;
      #3;
      total++; if (bus.fp_wb_fp_reg__rdst_idx !== 5'd11 || bus.fp_wb_fp_reg__rdst_data !== 64'hA0A0 ||
                   bus.fp_wb_fpu__rdy !== 1'b0) begin
         bad++; $display("FAIL starve_c4_skid got idx=%0d data=%h rdy=%b exp 11/a0a0/0",
                         bus.fp_wb_fp_reg__rdst_idx, bus.fp_wb_fp_reg__rdst_data, bus.fp_wb_fpu__rdy); end
      tick();
      #3;
      total++; if (bus.fp_wb_fp_reg__rdst_idx !== 5'd12 || bus.fp_wb_fp_reg__rdst_data !== 64'hB0B0 ||
                   bus.fp_wb_fpu__rdy !== 1'b1) begin
         bad++; $display("FAIL starve_c5_fpu got idx=%0d data=%h rdy=%b exp 12/b0b0/1",
                         bus.fp_wb_fp_reg__rdst_idx, bus.fp_wb_fp_reg__rdst_data, bus.fp_wb_fpu__rdy); end
      tick();
      drive_idle();
      #3;
      total++; if (bus.fp_wb_fp_reg__rdst_en !== 1'b0) begin bad++; $display("FAIL starve_drained got en=%b exp=0", bus.fp_wb_fp_reg__rdst_en); end
      tick();
   endtask

   task automatic test_alloc_same();
      bus.fpu_fp_wb__vld = 1'b1; bus.fpu_fp_wb__idx = 5'd7; bus.fpu_fp_wb__data = 64'h77;
      bus.dec_fp_wb__alloc_en = 1'b1; bus.dec_fp_wb__alloc_idx = 5'd7;
      tick();
      drive_idle();
      bus.dec_fp_wb__rs1_vld = 1'b1; bus.dec_fp_wb__rs1_idx = 5'd7;
      #3;
      total++; if (bus.fp_wb_dec__stall !== 1'b1) begin bad++; $display("FAIL alloc_set_wins got=%b exp=1", bus.fp_wb_dec__stall); end
      bus.fpu_fp_wb__vld = 1'b1; bus.fpu_fp_wb__idx = 5'd7; bus.fpu_fp_wb__data = 64'h78;
      tick();
      bus.fpu_fp_wb__vld = 1'b0;
      #3;
      total++; if (bus.fp_wb_dec__stall !== 1'b0) begin bad++; $display("FAIL alloc_cleared got=%b exp=0", bus.fp_wb_dec__stall); end
      drive_idle();
      tick();
   endtask

   task automatic test_flush();
      for (int r = 4; r < 8; r++) begin
         bus.dec_fp_wb__alloc_en = 1'b1; bus.dec_fp_wb__alloc_idx = 5'(r);
         tick();
      end
      drive_idle();
      bus.dec_fp_wb__rs3_vld = 1'b1; bus.dec_fp_wb__rs3_idx = 5'd6;
      bus.lsu_fp_wb__vld = 1'b1; bus.lsu_fp_wb__idx = 5'd1; bus.lsu_fp_wb__data = 64'h11;
      bus.fpu_fp_wb__vld = 1'b1; bus.fpu_fp_wb__idx = 5'd2; bus.fpu_fp_wb__data = 64'h22;
      #3;
      total++; if (bus.fp_wb_dec__stall !== 1'b1) begin bad++; $display("FAIL flush_pre_stall got=%b exp=1", bus.fp_wb_dec__stall); end
      tick();
      bus.fpu_fp_wb__vld = 1'b0;
      bus.lsu_fp_wb__idx = 5'd8; bus.lsu_fp_wb__data = 64'h88;
      flush = 1'b1;
      bus.dec_fp_wb__alloc_en = 1'b1; bus.dec_fp_wb__alloc_idx = 5'd9;
      #3;
      total++; if (bus.fp_wb_fp_reg__rdst_en !== 1'b1 || bus.fp_wb_fp_reg__rdst_idx !== 5'd8) begin
         bad++; $display("FAIL flush_cycle_write got en=%b idx=%0d exp 1/8", bus.fp_wb_fp_reg__rdst_en, bus.fp_wb_fp_reg__rdst_idx); end
      tick();
      drive_idle();
      bus.dec_fp_wb__rs1_vld = 1'b1; bus.dec_fp_wb__rs1_idx = 5'd4;
      bus.dec_fp_wb__rs2_vld = 1'b1; bus.dec_fp_wb__rs2_idx = 5'd9;
      bus.dec_fp_wb__rs3_vld = 1'b1; bus.dec_fp_wb__rs3_idx = 5'd6;
      bus.dec_fp_wb__rd_vld  = 1'b1; bus.dec_fp_wb__rd_idx  = 5'd7;
      #3;
      total++; if (bus.fp_wb_dec__stall !== 1'b0) begin bad++; $display("FAIL flush_busy_cleared got stall=%b exp=0", bus.fp_wb_dec__stall); end
      total++; if (bus.fp_wb_fpu__rdy !== 1'b1 || bus.fp_wb_fp_reg__rdst_en !== 1'b0) begin
         bad++; $display("FAIL flush_skid_cleared got rdy=%b en=%b exp 1/0", bus.fp_wb_fpu__rdy, bus.fp_wb_fp_reg__rdst_en); end
      drive_idle();
      tick();
   endtask

   task automatic test_async_reset();
      bus.dec_fp_wb__alloc_en = 1'b1; bus.dec_fp_wb__alloc_idx = 5'd9;
      tick();
      drive_idle();
      bus.lsu_fp_wb__vld = 1'b1; bus.lsu_fp_wb__idx = 5'd1; bus.lsu_fp_wb__data = 64'h1;
      bus.fpu_fp_wb__vld = 1'b1; bus.fpu_fp_wb__idx = 5'd2; bus.fpu_fp_wb__data = 64'h2;
      tick();
      drive_idle();
      bus.dec_fp_wb__rs1_vld = 1'b1; bus.dec_fp_wb__rs1_idx = 5'd9;
      #1;
      total++; if (bus.fp_wb_fpu__rdy !== 1'b0 || bus.fp_wb_dec__stall !== 1'b1 || bus.fp_wb_fp_reg__rdst_en !== 1'b1) begin
         bad++; $display("FAIL arst_before got rdy=%b stall=%b en=%b exp 0/1/1",
                         bus.fp_wb_fpu__rdy, bus.fp_wb_dec__stall, bus.fp_wb_fp_reg__rdst_en); end
      rst = 1'b1;
      #1;
      total++; if (bus.fp_wb_fpu__rdy !== 1'b1 || bus.fp_wb_dec__stall !== 1'b0 || bus.fp_wb_fp_reg__rdst_en !== 1'b0) begin
         bad++; $display("FAIL arst_immediate got rdy=%b stall=%b en=%b exp 1/0/0",
                         bus.fp_wb_fpu__rdy, bus.fp_wb_dec__stall, bus.fp_wb_fp_reg__rdst_en); end
      tick();
      rst = 1'b0;
      drive_idle();
      tick();
   endtask

   task automatic test_random();
      logic en; logic [IDXW-1:0] widx; logic [DWTH-1:0] wdata;
      logic hold = 1'b0;
      for (int n = 0; n < 500; n++) begin
         flush = ($urandom_range(0, 24) == 0);
         bus.dec_fp_wb__alloc_en  = $urandom_range(0, 2) == 0;
         bus.dec_fp_wb__alloc_idx = 5'($urandom);
         bus.dec_fp_wb__rs1_vld = $urandom_range(0, 1) == 1; bus.dec_fp_wb__rs1_idx = 5'($urandom);
         bus.dec_fp_wb__rs2_vld = $urandom_range(0, 1) == 1; bus.dec_fp_wb__rs2_idx = 5'($urandom);
         bus.dec_fp_wb__rs3_vld = $urandom_range(0, 1) == 1; bus.dec_fp_wb__rs3_idx = 5'($urandom);
         bus.dec_fp_wb__rd_vld  = $urandom_range(0, 1) == 1; bus.dec_fp_wb__rd_idx  = 5'($urandom);
         bus.lsu_fp_wb__vld  = $urandom_range(0, 9) < 4;
         bus.lsu_fp_wb__idx  = 5'($urandom);
         bus.lsu_fp_wb__data = DWTH'({$urandom(), $urandom()});
         if (!hold) begin
            bus.fpu_fp_wb__vld  = $urandom_range(0, 1) == 1;
            bus.fpu_fp_wb__idx  = 5'($urandom);
            bus.fpu_fp_wb__data = DWTH'({$urandom(), $urandom()});
         end
         #3;
         model_write(en, widx, wdata);
         total++; if (bus.fp_wb_fp_reg__rdst_en !== en || bus.fp_wb_fp_reg__rdst_idx !== widx ||
                      bus.fp_wb_fp_reg__rdst_data !== wdata) begin
            bad++; $display("FAIL rnd_write[%0d] got en=%b idx=%0d data=%h exp en=%b idx=%0d data=%h", n,
                            bus.fp_wb_fp_reg__rdst_en, bus.fp_wb_fp_reg__rdst_idx, bus.fp_wb_fp_reg__rdst_data,
                            en, widx, wdata); end
         total++; if (bus.fp_wb_fpu__rdy !== (m_skid.size() == 0)) begin
            bad++; $display("FAIL rnd_rdy[%0d] got=%b exp=%b", n, bus.fp_wb_fpu__rdy, m_skid.size() == 0); end
         total++; if (bus.fp_wb_dec__stall !== exp_stall()) begin
            bad++; $display("FAIL rnd_stall[%0d] got=%b exp=%b", n, bus.fp_wb_dec__stall, exp_stall()); end
         hold = bus.fpu_fp_wb__vld && (m_skid.size() != 0);
         tick();
      end
      drive_idle();
      repeat (3) tick();
   endtask

   initial begin
      rst = 1'b1;
      m_busy = '0;
      drive_idle();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_raw_stall();
      test_collision();
      test_lsu_starve();
      test_alloc_same();
      test_flush();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
